load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the datapath (effective address, store data, funct3, write/read strobe) and a word-organised data RAM.
- Converts byte, halfword and word loads/stores into word accesses with byte enables.
- Stores: shifts write data into the correct byte lanes. Loads: aligns and sign/zero-extends read data.
- Accesses that cross a word boundary are optionally split into two sequential RAM accesses.
- The core is held by a valid/ready handshake while an access is in flight.

Parameters:
- ADDR_W, 32, byte-address width; RAM word address is ADDR_W-2 bits.
- ALLOW_SPLIT, 1, 1 = word-crossing accesses take two RAM transactions; 0 = they complete with rsp_fault.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  core presents an access
- req_ready  output  1  unit can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign code
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, LSB-justified
- rsp_valid  output  1  one-cycle pulse, access finished
- rsp_rdata  output  32  extended load data; 0 for stores and faults
- rsp_fault  output  1  qualifies rsp_valid: illegal funct3, or word-crossing with ALLOW_SPLIT=0
- mem_req  output  1  RAM transaction strobe, one cycle per transaction
- mem_we  output  1  RAM write enable, valid with mem_req
- mem_addr  output  ADDR_W-2  RAM word address
- mem_be  output  4  byte enables, bit i = byte lane i
- mem_wdata  output  32  lane-aligned write data
- mem_rdata  input  32  RAM read data, valid with mem_rvalid
- mem_rvalid  input  1  read data return, any latency of at least 1 cycle

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready = 1. Internal capture registers cleared.
- Accept: req_valid & req_ready. Latch req_we, req_funct3, req_addr, req_wdata; stay busy until rsp_valid.
- Size and extension by funct3:
  - 000 LB/SB: size 1, sign-extend.
  - 001 LH/SH: size 2, sign-extend.
  - 010 LW/SW: size 4.
  - 100 LBU, 101 LHU: loads only, zero-extend.
  - Illegal: 011, 110, 111; and 100/101 on a store.
- Illegal funct3: go to RESP with rsp_fault = 1. No mem_req issued.
- Geometry: off = addr[1:0]. cross = off + size > 4.
- Lanes: be64 = ({size} ones) << off; wd64 = wdata << (8*off).
  - Word0: be64[3:0], wd64[31:0].
  - Word1: be64[7:4], wd64[63:32], at address word0+1 modulo 2^(ADDR_W-2).
- Misaligned but not crossing (e.g. LH at off 1): single access. It is not a fault.
- cross with ALLOW_SPLIT=0: RESP with rsp_fault = 1. No RAM access; a store writes nothing.
- States:
  - IDLE: on accept go to ISSUE0, or to RESP if faulting.
  - ISSUE0: mem_req = 1 for one cycle with word0.
    - Store: next is ISSUE1 if cross, else RESP.
    - Load: next is WAIT0.
  - WAIT0: on mem_rvalid, capture word0; next is ISSUE1 if cross, else RESP.
  - ISSUE1: mem_req = 1 for one cycle with word1.
    - Store: next is RESP.
    - Load: next is WAIT1.
  - WAIT1: on mem_rvalid, capture word1; next is RESP.
  - RESP: rsp_valid = 1 for one cycle; next is IDLE.
    - req_ready stays 0 in RESP; the next request is accepted in IDLE on the following cycle.
- Load result: ({word1, word0} >> 8*off), truncated to size, then extended.
  - For non-crossing loads, word1 is treated as 0.
- Latency, with mem_rvalid arriving one cycle after mem_req:
  - Aligned store: accept -> rsp_valid = 2 cycles.
  - Aligned load: 3 cycles.
  - Each split adds 1 cycle (store) or 2 cycles (load).
- mem_rvalid outside WAIT0/WAIT1 is ignored.
- mem_* outputs are registered. mem_we, mem_be and mem_wdata are 0 whenever mem_req = 0.
- Reset mid-operation: all outputs drop immediately. A captured partial load is discarded. No rsp_valid is emitted for the aborted access. Word0 of a split store may already be written; word1 is not.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF -> one mem_req: we=1, addr 0x40, be 1111, wdata 0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_fault 0.
- LB addr 0x103, RAM word 0x80123456 -> be 1000, rsp_rdata 0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr 0x203, wdata 0x0000ABCD, ALLOW_SPLIT=1 -> two transactions:
  - addr 0x80: be 1000, wdata 0xCD000000.
  - addr 0x81: be 0001, wdata 0x000000AB.
- LW addr 0xFFFFFFFE, ALLOW_SPLIT=1, word 0x3FFFFFFF = 0x1122AABB, word 0x0 = 0xCCDD3344 -> word1 address wraps to 0x0; rsp_rdata 0x33441122.
- LW addr 0x101, ALLOW_SPLIT=0 -> no mem_req, rsp_fault 1, rsp_rdata 0. Also funct3 011 -> rsp_fault 1, no mem_req.
- Assert rst in WAIT0 of a split load -> outputs 0 and req_ready 1 immediately; no rsp_valid; a later mem_rvalid is ignored; the next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word accesses onto a word-organised RAM,
// splitting word-crossing accesses into two sequential transactions when enabled.
module load_store_unit #(
    parameter int ADDR_W      = 32,
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP
    } state_t;

    localparam logic [ADDR_W-3:0] WA_ONE = {{(ADDR_W-3){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [2:0]          r_f3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_fault;
    logic [31:0]         r_word0;
    logic [31:0]         r_word1;

    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-3:0]   r_mem_addr;
    logic [3:0]          r_mem_be;
    logic [31:0]         r_mem_wdata;

    logic                w_idle;
    logic                w_accept;
    logic                w_we;
    logic [2:0]          w_f3;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_wdata;
    logic [1:0]          w_off;
    logic [2:0]          w_size;
    logic [3:0]          w_mask;
    logic                w_illegal;
    logic                w_cross;
    logic                w_fault;
    logic [7:0]          w_be64;
    logic [63:0]         w_wd64;
    logic [ADDR_W-3:0]   w_waddr0;
    logic [ADDR_W-3:0]   w_waddr1;

    logic                w_mreq;
    logic                w_mwe;
    logic [ADDR_W-3:0]   w_maddr;
    logic [3:0]          w_mbe;
    logic [31:0]         w_mwd;

    logic [31:0]         w_aligned;
    logic [31:0]         w_ext;

    // Geometry is computed from the live request in IDLE so the first
    // transaction can be registered on the accept edge; afterwards from the latch.
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & req_valid;
    assign w_we     = w_idle ? req_we     : r_we;
    assign w_f3     = w_idle ? req_funct3 : r_f3;
    assign w_addr   = w_idle ? req_addr   : r_addr;
    assign w_wdata  = w_idle ? req_wdata  : r_wdata;
    assign w_off    = w_addr[1:0];

    always_comb begin
        w_illegal = 1'b0;
        w_size    = 3'd4;
        w_mask    = 4'b1111;
        case (w_f3)
            3'b000: begin w_size = 3'd1; w_mask = 4'b0001; end
            3'b001: begin w_size = 3'd2; w_mask = 4'b0011; end
            3'b010: begin w_size = 3'd4; w_mask = 4'b1111; end
            3'b100: begin w_size = 3'd1; w_mask = 4'b0001; w_illegal = w_we; end
            3'b101: begin w_size = 3'd2; w_mask = 4'b0011; w_illegal = w_we; end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_cross  = (({1'b0, w_off} + w_size) > 3'd4);
    assign w_fault  = w_illegal | (w_cross & ~ALLOW_SPLIT);
    assign w_be64   = {4'b0000, w_mask} << w_off;
    assign w_wd64   = {32'h0, w_wdata} << {w_off, 3'b000};
    assign w_waddr0 = w_addr[ADDR_W-1:2];
    assign w_waddr1 = w_waddr0 + WA_ONE;

    always_comb begin
        w_next  = r_state;
        w_mreq  = 1'b0;
        w_mwe   = 1'b0;
        w_maddr = '0;
        w_mbe   = '0;
        w_mwd   = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_fault) begin
                        w_next = S_RESP;
                    end else begin
                        w_next  = S_ISSUE0;
                        w_mreq  = 1'b1;
                        w_mwe   = w_we;
                        w_maddr = w_waddr0;
                        w_mbe   = w_be64[3:0];
                        w_mwd   = w_we ? w_wd64[31:0] : '0;
                    end
                end
            end
            S_ISSUE0, S_WAIT0: begin
                if ((r_state == S_ISSUE0 && w_we) || (r_state == S_WAIT0 && mem_rvalid)) begin
                    if (w_cross) begin
                        w_next  = S_ISSUE1;
                        w_mreq  = 1'b1;
                        w_mwe   = w_we;
                        w_maddr = w_waddr1;
                        w_mbe   = w_be64[7:4];
                        w_mwd   = w_we ? w_wd64[63:32] : '0;
                    end else begin
                        w_next = S_RESP;
                    end
                end else if (r_state == S_ISSUE0) begin
                    w_next = S_WAIT0;
                end
            end
            S_ISSUE1: w_next = w_we ? S_RESP : S_WAIT1;
            S_WAIT1: begin
                if (mem_rvalid) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_f3        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_fault     <= 1'b0;
            r_word0     <= '0;
            r_word1     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_next;
            r_mem_req   <= w_mreq;
            r_mem_we    <= w_mwe;
            r_mem_addr  <= w_maddr;
            r_mem_be    <= w_mbe;
            r_mem_wdata <= w_mwd;
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_fault <= w_fault;
                r_word0 <= '0;
                r_word1 <= '0;
            end
            if (r_state == S_WAIT0 && mem_rvalid) begin
                r_word0 <= mem_rdata;
            end
            if (r_state == S_WAIT1 && mem_rvalid) begin
                r_word1 <= mem_rdata;
            end
        end
    end

    assign w_aligned = 32'({r_word1, r_word0} >> {r_addr[1:0], 3'b000});

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{w_aligned[7]}}, w_aligned[7:0]};
            3'b001:  w_ext = {{16{w_aligned[15]}}, w_aligned[15:0]};
            3'b100:  w_ext = {24'h0, w_aligned[7:0]};
            3'b101:  w_ext = {16'h0, w_aligned[15:0]};
            default: w_ext = w_aligned;
        endcase
    end

    assign req_ready = w_idle;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_fault = (r_state == S_RESP) & r_fault;
    assign rsp_rdata = ((r_state == S_RESP) && !r_we && !r_fault) ? w_ext : '0;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a split-enabled instance backed by a
// RAM model, plus a split-disabled instance exercised with faulting accesses.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid_a;
    logic        req_valid_b;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        a_req_ready, a_rsp_valid, a_rsp_fault, a_mem_req, a_mem_we;
    logic [31:0] a_rsp_rdata, a_mem_wdata;
    logic [29:0] a_mem_addr;
    logic [3:0]  a_mem_be;

    logic        b_req_ready, b_rsp_valid, b_rsp_fault, b_mem_req, b_mem_we;
    logic [31:0] b_rsp_rdata, b_mem_wdata;
    logic [29:0] b_mem_addr;
    logic [3:0]  b_mem_be;

    logic        rv_model;
    logic [31:0] rd_model;
    logic        stray_rv;
    logic [31:0] stray_rd;
    logic        mute;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } mtx_t;

    typedef struct packed {
        logic [31:0] rd;
        logic        f;
    } rsp_t;

    mtx_t mq[$];
    rsp_t rqa[$];
    rsp_t rqb[$];
    logic [31:0] ram [logic [29:0]];

    int n_tests;
    int n_fail;

    load_store_unit #(.ADDR_W(32), .ALLOW_SPLIT(1'b1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(a_req_ready),
        .req_we(req_we), .req_funct3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
        .mem_rdata(stray_rv ? stray_rd : rd_model), .mem_rvalid(rv_model | stray_rv)
    );

    load_store_unit #(.ADDR_W(32), .ALLOW_SPLIT(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(b_req_ready),
        .req_we(req_we), .req_funct3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
        .mem_rdata(32'h0), .mem_rvalid(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [29:0] a);
        return ram.exists(a) ? ram[a] : 32'h0;
    endfunction

    task automatic push_m(input logic we, input logic [29:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
        mtx_t t;
        t.we = we; t.addr = addr; t.be = be; t.wd = wd;
        mq.push_back(t);
    endtask

    // RAM model: read data returns in the cycle after mem_req
    initial begin
        logic        pend;
        logic [31:0] pend_d;
        logic [31:0] old;
        pend = 1'b0; pend_d = '0; rv_model = 1'b0; rd_model = '0;
        forever begin
            @(negedge clk);
            rv_model = pend & ~mute;
            rd_model = pend_d;
            pend     = a_mem_req & ~a_mem_we & ~rst;
            pend_d   = ram_rd(a_mem_addr);
            if (a_mem_req && a_mem_we) begin
                old = ram_rd(a_mem_addr);
                for (int unsigned i = 0; i < 4; i++) begin
                    if (a_mem_be[i]) old[8*i +: 8] = a_mem_wdata[8*i +: 8];
                end
                ram[a_mem_addr] = old;
            end
        end
    end

    // Monitor: pops expected transactions/responses whenever the DUTs present them
    initial begin
        mtx_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (a_mem_req) begin
                    if (mq.size() == 0) begin
                        check("mem_req_unexpected", {63'h0, a_mem_req}, 64'h0);
                    end else begin
                        e = mq.pop_front();
                        check("mem_we", {63'h0, a_mem_we}, {63'h0, e.we});
                        check("mem_addr", {34'h0, a_mem_addr}, {34'h0, e.addr});
                        check("mem_be", {60'h0, a_mem_be}, {60'h0, e.be});
                        if (e.we) check("mem_wdata", {32'h0, a_mem_wdata}, {32'h0, e.wd});
                    end
                end else begin
                    check("mem_idle_zero", {27'h0, a_mem_we, a_mem_be, a_mem_wdata}, 64'h0);
                end
                if (a_rsp_valid) begin
                    if (rqa.size() == 0) begin
                        check("rsp_unexpected", {63'h0, a_rsp_valid}, 64'h0);
                    end else begin
                        r = rqa.pop_front();
                        check("rsp_rdata", {32'h0, a_rsp_rdata}, {32'h0, r.rd});
                        check("rsp_fault", {63'h0, a_rsp_fault}, {63'h0, r.f});
                    end
                end
                if (b_mem_req) check("b_mem_req_unexpected", {63'h0, b_mem_req}, 64'h0);
                if (b_rsp_valid) begin
                    if (rqb.size() == 0) begin
                        check("b_rsp_unexpected", {63'h0, b_rsp_valid}, 64'h0);
                    end else begin
                        r = rqb.pop_front();
                        check("b_rsp_rdata", {32'h0, b_rsp_rdata}, {32'h0, r.rd});
                        check("b_rsp_fault", {63'h0, b_rsp_fault}, {63'h0, r.f});
                    end
                end
            end
        end
    end

    task automatic do_req(input bit b, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
        rsp_t r;
        int   lat;
        r.rd = exp_rd; r.f = exp_f;
        if (b) rqb.push_back(r); else rqa.push_back(r);
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            if (b ? b_req_ready : a_req_ready) break;
            @(negedge clk);
        end
        req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
        if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b ? b_rsp_valid : a_rsp_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; mute = 1'b0; stray_rv = 1'b0; stray_rd = '0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; req_f3 = '0; req_addr = '0; req_wdata = '0;
        #12;
        check("reset_ready", {62'h0, a_req_ready, b_req_ready}, 64'h3);
        check("reset_rsp", {30'h0, a_rsp_valid, a_rsp_fault, a_rsp_rdata}, 64'h0);
        check("reset_mem", {26'h0, a_mem_req, a_mem_we, a_mem_be, a_mem_wdata}, 64'h0);
        check("reset_mem_addr", {34'h0, a_mem_addr}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // aligned store
        push_m(1'b1, 30'h40, 4'b1111, 32'hDEADBEEF);
        do_req(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("ram_after_sw", {32'h0, ram_rd(30'h40)}, {32'h0, 32'hDEADBEEF});

        // byte loads, signed and unsigned, off 3
        ram[30'h40] = 32'h80123456;
        push_m(1'b0, 30'h40, 4'b1000, 32'h0);
        do_req(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        push_m(1'b0, 30'h40, 4'b1000, 32'h0);
        do_req(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 32'h00000080, 1'b0, 3);

        // misaligned, non-crossing halfword loads
        push_m(1'b0, 30'h40, 4'b1100, 32'h0);
        do_req(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8012, 1'b0, 3);
        push_m(1'b0, 30'h40, 4'b0110, 32'h0);
        do_req(1'b0, 1'b0, 3'b001, 32'h101, 32'h0, 32'h00001234, 1'b0, 3);

        // byte store into lane 1, then read back unsigned
        push_m(1'b1, 30'h40, 4'b0010, 32'h00007700);
        do_req(1'b0, 1'b1, 3'b000, 32'h101, 32'h00000077, 32'h0, 1'b0, 2);
        push_m(1'b0, 30'h40, 4'b0010, 32'h0);
        do_req(1'b0, 1'b0, 3'b100, 32'h101, 32'h0, 32'h00000077, 1'b0, 3);

        // split halfword store, then split loads back
        push_m(1'b1, 30'h80, 4'b1000, 32'hCD000000);
        push_m(1'b1, 30'h81, 4'b0001, 32'h000000AB);
        do_req(1'b0, 1'b1, 3'b001, 32'h203, 32'h0000ABCD, 32'h0, 1'b0, 3);
        push_m(1'b0, 30'h80, 4'b1000, 32'h0);
        push_m(1'b0, 30'h81, 4'b0001, 32'h0);
        do_req(1'b0, 1'b0, 3'b001, 32'h203, 32'h0, 32'hFFFFABCD, 1'b0, 5);
        push_m(1'b0, 30'h80, 4'b1000, 32'h0);
        push_m(1'b0, 30'h81, 4'b0001, 32'h0);
        do_req(1'b0, 1'b0, 3'b101, 32'h203, 32'h0, 32'h0000ABCD, 1'b0, 5);

        // split word load wrapping the top of the address space
        ram[30'h3FFFFFFF] = 32'h1122AABB;
        ram[30'h0]        = 32'hCCDD3344;
        push_m(1'b0, 30'h3FFFFFFF, 4'b1100, 32'h0);
        push_m(1'b0, 30'h0, 4'b0011, 32'h0);
        do_req(1'b0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h33441122, 1'b0, 5);

        // illegal funct3 on the split-enabled unit
        do_req(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1);
        do_req(1'b0, 1'b1, 3'b100, 32'h100, 32'h12345678, 32'h0, 1'b1, 1);
        check("ram_untouched", {32'h0, ram_rd(30'h40)}, {32'h0, 32'h80127756});

        // split-disabled unit: crossings and illegal codes all fault
        do_req(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 1);
        do_req(1'b1, 1'b1, 3'b001, 32'h203, 32'h0000ABCD, 32'h0, 1'b1, 1);
        do_req(1'b1, 1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 1'b1, 1);

        // reset while waiting on word0 of a split load
        mute = 1'b1;
        push_m(1'b0, 30'hC0, 4'b1100, 32'h0);
        @(negedge clk);
        req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h302; req_wdata = '0;
        req_valid_a = 1'b1;
        @(posedge clk);
        #1 req_valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wait0_not_ready", {63'h0, a_req_ready}, 64'h0);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", {63'h0, a_req_ready}, 64'h1);
        check("rst_mid_outputs", {29'h0, a_mem_req, a_rsp_valid, a_rsp_fault, a_rsp_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b0; mute = 1'b0;
        @(negedge clk);
        stray_rv = 1'b1; stray_rd = 32'hFFFFFFFF;
        @(negedge clk);
        stray_rv = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_after_stray", {62'h0, a_req_ready, a_mem_req}, 64'h2);
        end
        push_m(1'b0, 30'h40, 4'b1111, 32'h0);
        do_req(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h80127756, 1'b0, 3);

        repeat (3) @(negedge clk);
        check("mem_queue_drained", 64'(mq.size()), 64'h0);
        check("rsp_queue_drained", 64'(rqa.size() + rqb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
